bit_serial_acc_sequencer: RTL and testbench
===========================================

Name: bit_serial_acc_sequencer

Overview:
Control sequencer for the bit-serial shift-accumulate datapath: the 8-bit shift accumulator, a serial adder with carry flop, and a multiplier-bit mux.
- Accepts a start/done job request carrying a pass count.
- Clears the accumulator by shifting in zeros for WIDTH cycles.
- Runs P shift-add passes of WIDTH cycles each.
- On the final bit of every pass, asserts the sign-select control so the accumulator MSB takes the adder sign (arithmetic shift).
- Sits between the job issue logic and the datapath; it is the only driver of the accumulator shift/sign controls.

Parameters:
- WIDTH, 8, accumulator/operand width in bits (≥2).
- CW, $clog2(WIDTH), width of bit and pass index outputs.
- PW, $clog2(WIDTH+1), width of pass count input.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  job request, sampled in IDLE only.
- i_num_passes  in  PW  pass count P, captured with accepted start.
- i_stall  in  1  freeze sequencing; no shift while high.
- i_abort  in  1  synchronous abort to IDLE.
- o_busy  out  1  high in CLEAR and PASS.
- o_done  out  1  one-cycle completion pulse.
- o_con_shift  out  1  accumulator shift enable.
- o_con_sign  out  1  accumulator MSB takes adder sign.
- o_zero_sel  out  1  datapath feeds 0 into accumulator (CLEAR).
- o_carry_clr  out  1  clear serial-adder carry before the pass's bit 0.
- o_bit_idx  out  CW  current bit within word (0..WIDTH-1).
- o_pass_idx  out  CW  current pass index (multiplier bit select).

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; bit counter, pass counter and captured P all 0.

FSM states: IDLE, CLEAR, PASS, DONE.

- IDLE:
  - All outputs 0.
  - i_start=1 captures P = min(i_num_passes, WIDTH), then moves to CLEAR with bit_idx=0.
- CLEAR:
  - o_busy=1, o_zero_sel=1, o_con_shift=!i_stall.
  - bit_idx advances on each unstalled cycle.
  - Unstalled cycle at bit_idx=WIDTH-1: go to PASS with bit_idx=0, pass_idx=0. If P=0, go to DONE instead.
- PASS:
  - o_busy=1, o_con_shift=!i_stall.
  - o_carry_clr=1 when bit_idx=0.
  - o_con_sign=1 when bit_idx=WIDTH-1.
  - Unstalled cycle at bit_idx=WIDTH-1:
    - pass_idx=P-1: go to DONE.
    - otherwise: pass_idx+1, bit_idx wraps to 0.
- DONE: o_done=1 for exactly one cycle, unconditionally; then IDLE. o_busy=0.

Stall:
- Counters and state frozen; o_con_shift=0 and o_con_sign=0.
- o_carry_clr, o_zero_sel and the index outputs hold their values.
- No effect in IDLE or DONE.

Abort:
- In CLEAR or PASS: next state IDLE, all outputs 0 next cycle, no o_done. Abort beats stall.
- Ignored in IDLE and DONE.

Latency:
- Start high in cycle 0 and no stalls: CLEAR occupies cycles 1..WIDTH, PASS occupies WIDTH+1..WIDTH(P+1), o_done is high in cycle WIDTH(P+1)+1.
- Each stalled cycle adds exactly one cycle.

Boundary conditions:
- i_start while busy or in DONE is ignored, not queued.
- i_num_passes > WIDTH is clamped to WIDTH.
- Back-to-back jobs: start may be accepted in the IDLE cycle immediately after DONE.

Outputs: all registered from state/counters, or combinational from state and i_stall only. No combinational path from i_start.

Decomposition:
- Package bs_pkg:
  - state typedef enum {IDLE, CLEAR, PASS, DONE}.
  - Default WIDTH constant.
- One natural sub-module: bs_bit_counter, a mod-WIDTH counter with enable, sync clear and terminal-count output. The sequencer instantiates it for bit_idx; the pass counter stays inline.

Test Plan:
- Reset mid-PASS (i_rst pulse at bit_idx=3, pass 1) -> all outputs 0 immediately (asynchronous); IDLE; a fresh start then runs a full job.
- WIDTH=8, start with P=3, no stalls:
  - o_zero_sel high cycles 1-8.
  - o_carry_clr in cycles 9, 17, 25.
  - o_con_sign in cycles 16, 24, 32.
  - o_done in cycle 33; exactly 32 o_con_shift pulses.
- P=0 -> 8 CLEAR shifts, o_done in cycle 9, no o_con_sign ever.
- P=2 with i_stall high for 3 cycles at pass 0, bit 7 -> o_con_shift and o_con_sign low while stalled; o_con_sign fires once when released; o_done in cycle 28.
- Abort in pass 1, bit 4, together with stall -> IDLE next cycle, no o_done. A start in the same cycle as DONE is ignored; a start in the following cycle is accepted.
- i_num_passes=12 -> clamped to 8; o_done in cycle 73; o_pass_idx reaches 7 and never wraps.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and defaults for the bit-serial shift-accumulate sequencer.
package bs_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PASS  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bs_bit_counter.sv
// Mod-WIDTH up counter with enable, synchronous clear (clear wins) and terminal-count flag.
module bs_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_cnt = cnt_q;
    assign o_tc  = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_tc ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bit_serial_acc_sequencer.sv
// Sequences accumulator clear and P shift-add passes for the bit-serial datapath.
// Outputs decode only state, counters and i_stall; i_start only steers the next state.
module bit_serial_acc_sequencer
    import bs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = $clog2(WIDTH),
    parameter int PW    = $clog2(WIDTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [PW-1:0] i_num_passes,
    input  logic          i_stall,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_con_shift,
    output logic          o_con_sign,
    output logic          o_zero_sel,
    output logic          o_carry_clr,
    output logic [CW-1:0] o_bit_idx,
    output logic [CW-1:0] o_pass_idx
);

    state_t        state_q, state_d;
    logic [CW-1:0] pass_q, pass_d;
    logic [PW-1:0] num_q, num_d;
    logic [PW-1:0] num_clamped;
    logic [CW-1:0] bit_idx;
    logic          bit_tc, bit_en, bit_clr;
    logic          active, last_pass;

    assign active      = (state_q == CLEAR) || (state_q == PASS);
    assign bit_en      = active && !i_stall && !i_abort;
    assign last_pass   = (PW'(pass_q) + PW'(1)) == num_q;
    assign num_clamped = (i_num_passes > PW'(WIDTH)) ? PW'(WIDTH) : i_num_passes;

    bs_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (bit_en),
        .i_clr (bit_clr),
        .o_cnt (bit_idx),
        .o_tc  (bit_tc)
    );

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        num_d   = num_q;
        bit_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = CLEAR;
                    num_d   = num_clamped;
                    pass_d  = '0;
                    bit_clr = 1'b1;
                end
            end
            CLEAR: begin
                if (i_abort) begin
                    state_d = IDLE;
                    pass_d  = '0;
                    bit_clr = 1'b1;
                end else if (!i_stall && bit_tc) begin
                    state_d = (num_q == '0) ? DONE : PASS;
                    pass_d  = '0;
                end
            end
            PASS: begin
                if (i_abort) begin
                    state_d = IDLE;
                    pass_d  = '0;
                    bit_clr = 1'b1;
                end else if (!i_stall && bit_tc) begin
                    // Index returns to 0 on completion so DONE/IDLE present clean indices.
                    if (last_pass) begin
                        state_d = DONE;
                        pass_d  = '0;
                    end else begin
                        pass_d  = pass_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            pass_q  <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            num_q   <= num_d;
        end
    end

    assign o_busy      = active;
    assign o_done      = (state_q == DONE);
    assign o_con_shift = active && !i_stall;
    assign o_con_sign  = (state_q == PASS) && bit_tc && !i_stall;
    assign o_zero_sel  = (state_q == CLEAR);
    assign o_carry_clr = (state_q == PASS) && (bit_idx == '0);
    assign o_bit_idx   = bit_idx;
    assign o_pass_idx  = pass_q;

endmodule

// File: tb/tb_bit_serial_acc_sequencer.sv
// Bench for bit_serial_acc_sequencer: vector table, timed corner sequences, random run vs job-position model.
module tb_bit_serial_acc_sequencer;

    localparam int W  = 8;
    localparam int CW = 3;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] np = '0;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic          o_busy, o_done, o_con_shift, o_con_sign, o_zero_sel, o_carry_clr;
    logic [CW-1:0] o_bit_idx, o_pass_idx;

    bit_serial_acc_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_num_passes (np),
        .i_stall      (stall),
        .i_abort      (abort),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_con_shift  (o_con_shift),
        .o_con_sign   (o_con_sign),
        .o_zero_sel   (o_zero_sel),
        .o_carry_clr  (o_carry_clr),
        .o_bit_idx    (o_bit_idx),
        .o_pass_idx   (o_pass_idx)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    // Model: a job is a position t counting completed shifts; clear is t<W, pass k covers t in [W(k+1), W(k+2)).
    bit m_busy, m_done;
    int m_t, m_p;

    int cyc, n_shift, zero_first, zero_last, max_pass, prev_pass;
    bit pass_wrap, prev_busy;
    int sign_q[$];
    int carry_q[$];
    int done_q[$];
    logic [11:0] obs;

    typedef struct {
        bit          s;
        int          n;
        bit          stl;
        bit          ab;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[13];

    function automatic logic [11:0] mk(input bit b, input bit d, input bit sh, input bit sg,
                                       input bit z, input bit c, input int bi, input int pi);
        logic [2:0] b3, p3;
        b3 = 3'(bi);
        p3 = 3'(pi);
        return {b, d, sh, sg, z, c, b3, p3};
    endfunction

    function automatic logic [11:0] cur_out();
        return {o_busy, o_done, o_con_shift, o_con_sign, o_zero_sel, o_carry_clr, o_bit_idx, o_pass_idx};
    endfunction

    function automatic logic [11:0] model_out(input bit stl);
        bit sh, sg, z, c;
        int bi, pi;
        sh = m_busy && !stl;
        z  = m_busy && (m_t < W);
        c  = m_busy && (m_t >= W) && (m_t % W == 0);
        sg = m_busy && (m_t >= W) && (m_t % W == W - 1) && !stl;
        bi = m_busy ? m_t % W : 0;
        pi = (m_busy && m_t >= W) ? m_t / W - 1 : 0;
        return mk(m_busy, m_done, sh, sg, z, c, bi, pi);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_t = 0; m_p = 0;
    endtask

    task automatic model_step(input bit s, input int n, input bit stl, input bit ab);
        if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1;
                m_t    = 0;
                m_p    = (n > W) ? W : n;
            end
        end else if (ab) begin
            m_busy = 0;
        end else if (!stl) begin
            m_t++;
            if (m_t == W * (m_p + 1)) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic scn_begin();
        cyc = 0; n_shift = 0; zero_first = -1; zero_last = -1;
        max_pass = 0; prev_pass = 0; pass_wrap = 0; prev_busy = 0;
        sign_q.delete(); carry_q.delete(); done_q.delete();
    endtask

    // Entered 1 time unit after a rising edge; samples at the falling edge.
    task automatic tick(input bit s, input int n, input bit stl, input bit ab);
        start = s; np = PW'(n); stall = stl; abort = ab;
        #4;
        obs = cur_out();
        check("model", {20'd0, obs}, {20'd0, model_out(stl)});
        if (o_con_shift) n_shift++;
        if (o_con_sign) sign_q.push_back(cyc);
        if (o_carry_clr) carry_q.push_back(cyc);
        if (o_done) done_q.push_back(cyc);
        if (o_zero_sel) begin
            if (zero_first < 0) zero_first = cyc;
            zero_last = cyc;
        end
        if (o_busy && prev_busy && int'(o_pass_idx) < prev_pass) pass_wrap = 1;
        if (o_busy && int'(o_pass_idx) > max_pass) max_pass = int'(o_pass_idx);
        prev_busy = o_busy;
        prev_pass = int'(o_pass_idx);
        model_step(s, n, stl, ab);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic int first_done();
        return (done_q.size() > 0) ? done_q[0] : -1;
    endfunction

    initial begin
        // P=0 job with a stall in CLEAR, start during DONE, abort/stall in IDLE.
        vecs[0]  = '{1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{0, 0, 0, 0, mk(1, 0, 1, 0, 1, 0, 0, 0)};
        vecs[2]  = '{0, 0, 1, 0, mk(1, 0, 0, 0, 1, 0, 1, 0)};
        vecs[3]  = '{0, 0, 0, 0, mk(1, 0, 1, 0, 1, 0, 1, 0)};
        for (int b = 2; b < 8; b++) vecs[b + 2] = '{0, 0, 0, 0, mk(1, 0, 1, 0, 1, 0, b, 0)};
        vecs[10] = '{1, 5, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[11] = '{0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[12] = '{0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};

        model_reset();
        scn_begin();
        #2;
        check("reset_state", {20'd0, cur_out()}, 32'd0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        scn_begin();
        for (int i = 0; i < 13; i++) begin
            tick(vecs[i].s, vecs[i].n, vecs[i].stl, vecs[i].ab);
            check($sformatf("vec%0d", i), {20'd0, obs}, {20'd0, vecs[i].exp});
        end

        // P=3, no stalls.
        scn_begin();
        tick(1, 3, 0, 0);
        for (int c = 1; c < 200 && done_q.size() == 0; c++) tick(0, 0, 0, 0);
        check("p3_zero_first", zero_first, 1);
        check("p3_zero_last", zero_last, 8);
        check("p3_carry_n", carry_q.size(), 3);
        check("p3_sign_n", sign_q.size(), 3);
        for (int k = 0; k < 3 && k < carry_q.size() && k < sign_q.size(); k++) begin
            check($sformatf("p3_carry%0d", k), carry_q[k], 9 + 8 * k);
            check($sformatf("p3_sign%0d", k), sign_q[k], 16 + 8 * k);
        end
        check("p3_done", first_done(), 33);
        check("p3_shifts", n_shift, 32);

        // P=0.
        scn_begin();
        tick(1, 0, 0, 0);
        for (int c = 1; c < 100 && done_q.size() == 0; c++) tick(0, 0, 0, 0);
        check("p0_done", first_done(), 9);
        check("p0_shifts", n_shift, 8);
        check("p0_signs", sign_q.size(), 0);

        // P=2 with a 3-cycle stall on the sign bit of pass 0.
        scn_begin();
        tick(1, 2, 0, 0);
        for (int c = 1; c < 200 && done_q.size() == 0; c++) tick(0, 0, (c >= 16 && c <= 18), 0);
        check("stall_sign_n", sign_q.size(), 2);
        if (sign_q.size() == 2) begin
            check("stall_sign0", sign_q[0], 19);
            check("stall_sign1", sign_q[1], 27);
        end
        check("stall_shifts", n_shift, 24);
        check("stall_done", first_done(), 28);

        // Abort with stall at pass 1, bit 4.
        scn_begin();
        tick(1, 3, 0, 0);
        for (int c = 1; c < 21; c++) tick(0, 0, 0, 0);
        check("abort_pos", {26'd0, o_bit_idx, o_pass_idx}, {26'd0, 3'd4, 3'd1});
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 0);
        check("abort_idle", {20'd0, obs}, 32'd0);
        for (int c = 0; c < 40; c++) tick(0, 0, 0, 0);
        check("abort_no_done", done_q.size(), 0);

        // Start during DONE ignored, start in the following IDLE cycle accepted.
        scn_begin();
        tick(1, 0, 0, 0);
        for (int c = 1; c < 9; c++) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("b2b_done9", {31'd0, obs[10]}, 32'd1);
        tick(1, 0, 0, 0);
        check("b2b_idle10", {31'd0, obs[11]}, 32'd0);
        for (int c = 0; c < 40 && done_q.size() < 2; c++) tick(0, 0, 0, 0);
        check("b2b_done_n", done_q.size(), 2);
        if (done_q.size() == 2) check("b2b_done2", done_q[1], 19);

        // Pass count clamp.
        scn_begin();
        tick(1, 12, 0, 0);
        for (int c = 1; c < 300 && done_q.size() == 0; c++) tick(0, 0, 0, 0);
        check("clamp_done", first_done(), 73);
        check("clamp_max_pass", max_pass, 7);
        check("clamp_no_wrap", {31'd0, pass_wrap}, 32'd0);

        // Asynchronous reset in pass 1, bit 3, then a fresh job.
        scn_begin();
        tick(1, 3, 0, 0);
        for (int c = 1; c < 20; c++) tick(0, 0, 0, 0);
        #1;
        check("rst_pos", {26'd0, o_bit_idx, o_pass_idx}, {26'd0, 3'd3, 3'd1});
        rst = 1'b1;
        #1;
        check("rst_async", {20'd0, cur_out()}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        scn_begin();
        tick(1, 1, 0, 0);
        for (int c = 1; c < 100 && done_q.size() == 0; c++) tick(0, 0, 0, 0);
        check("rst_fresh_done", first_done(), 17);

        // Random traffic against the model.
        scn_begin();
        for (int c = 0; c < 4000; c++) begin
            tick($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
